decode_stage: RTL and testbench

- Registered RV32I instruction-decode pipeline stage, parametrised in data width and register-file depth.
- Sits between the fetch stage and the execute stage.
- Emits the same control bundle as the single-cycle decoder (ALU op, branch type, RAM controls, operand/writeback mux selects), plus register indices, a sign-extended immediate, an illegal-instruction flag and a pass-through PC.
- Adds a valid/ready handshake, flush, load-use bubble insertion and a stall counter.

---
 rtl/decode_stage.sv | 214 +++++++++++++++++++++
 tb/tb_decode_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32I decode stage with valid/ready, flush, load-use bubbles and stall counter
// Optional RV32M decode enabled by defining DECODE_M_EXT_EN.
module decode_stage #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 16,
    localparam int RW      = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_alu_op,
    output logic [1:0]       out_br_type,
    output logic             out_reg_we,
    output logic [RW-1:0]    out_rd,
    output logic [RW-1:0]    out_rs1,
    output logic [RW-1:0]    out_rs2,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_ram_we,
    output logic             out_ram_re,
    output logic [3:0]       out_ram_type,
    output logic             out_ram_sign,
    output logic             out_op1_sel,
    output logic             out_op2_sel,
    output logic             out_br_ret_sel,
    output logic             out_br_addr_sel,
    output logic [1:0]       out_wb_sel,
    output logic             out_illegal,
    output logic [CNT_W-1:0] stall_count
);
    localparam logic [6:0] OPC_LUI = 7'h37, OPC_AUIPC = 7'h17, OPC_JAL = 7'h6F, OPC_JALR = 7'h67;
    localparam logic [6:0] OPC_BR = 7'h63, OPC_LOAD = 7'h03, OPC_STORE = 7'h23, OPC_IMM = 7'h13, OPC_OP = 7'h33;
    localparam logic [4:0] ALU_ADD = 5'd1, ALU_SUB = 5'd2, ALU_SLL = 5'd3, ALU_SLT = 5'd4, ALU_SLTU = 5'd5;
    localparam logic [4:0] ALU_XOR = 5'd6, ALU_SRL = 5'd7, ALU_SRA = 5'd8, ALU_OR = 5'd9, ALU_AND = 5'd10;
    localparam logic [4:0] ALU_BEQ = 5'd11, ALU_BNE = 5'd12, ALU_BLT = 5'd13, ALU_BGE = 5'd14;
    localparam logic [4:0] ALU_BLTU = 5'd15, ALU_BGEU = 5'd16, ALU_LUI = 5'd17;
    localparam logic [1:0] BR_NONE = 2'd0, BR_JAL = 2'd1, BR_JALR = 2'd2, BR_BR = 2'd3;
    localparam logic [1:0] WB_NO_DATA = 2'd0, WB_ALU_OUT = 2'd1, WB_LOAD_DATA = 2'd2, WB_RET_ADDR = 2'd3;
    localparam logic [3:0] RAM_BYTE = 4'h1, RAM_HALF = 4'h3, RAM_FULL = 4'hF;

    typedef enum logic {S_RUN, S_BUBBLE} state_t;

    function automatic logic [4:0] alu_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    alu_f3 = ALU_ADD;
            3'd1:    alu_f3 = ALU_SLL;
            3'd2:    alu_f3 = ALU_SLT;
            3'd3:    alu_f3 = ALU_SLTU;
            3'd4:    alu_f3 = ALU_XOR;
            3'd5:    alu_f3 = alt ? ALU_SRA : ALU_SRL;
            3'd6:    alu_f3 = ALU_OR;
            default: alu_f3 = ALU_AND;
        endcase
    endfunction

    function automatic logic [3:0] ram_size(input logic [1:0] f3lo);
        case (f3lo)
            2'd0:    ram_size = RAM_BYTE;
            2'd1:    ram_size = RAM_HALF;
            2'd2:    ram_size = RAM_FULL;
            default: ram_size = 4'h0;
        endcase
    endfunction

    logic [6:0]  w_opc, w_f7;
    logic [2:0]  w_f3;
    logic [RW-1:0] w_rd, w_rs1, w_rs2;
    logic        w_ill, w_we, w_rwe, w_rre, w_rsign, w_op1, w_op2, w_bret, w_baddr, w_u1, w_u2;
    logic [4:0]  w_alu;
    logic [1:0]  w_br, w_wb;
    logic [3:0]  w_rtype;
    logic [31:0] w_imm32;
    logic        w_hazard, w_in_fire;

    state_t          r_state;
    logic            r_valid, r_reg_we, r_ram_we, r_ram_re, r_ram_sign, r_illegal;
    logic            r_op1_sel, r_op2_sel, r_br_ret_sel, r_br_addr_sel;
    logic [XLEN-1:0] r_pc, r_imm;
    logic [4:0]      r_alu_op;
    logic [1:0]      r_br_type, r_wb_sel;
    logic [RW-1:0]   r_rd, r_rs1, r_rs2;
    logic [3:0]      r_ram_type;
    logic [CNT_W-1:0] r_stall;

    assign w_opc = in_instr[6:0];
    assign w_f3  = in_instr[14:12];
    assign w_f7  = in_instr[31:25];
    assign w_rd  = in_instr[7 +: RW];
    assign w_rs1 = in_instr[15 +: RW];
    assign w_rs2 = in_instr[20 +: RW];

    always_comb begin
        w_ill = 1'b0; w_alu = 5'd0; w_br = BR_NONE; w_we = 1'b0; w_imm32 = 32'd0;
        w_rwe = 1'b0; w_rre = 1'b0; w_rtype = 4'h0; w_rsign = 1'b1;
        w_op1 = 1'b0; w_op2 = 1'b0; w_bret = 1'b0; w_baddr = 1'b0;
        w_wb = WB_NO_DATA; w_u1 = 1'b1; w_u2 = 1'b0;
        case (w_opc)
            OPC_LUI: begin
                w_alu = ALU_LUI; w_imm32 = {in_instr[31:12], 12'd0};
                w_we = 1'b1; w_wb = WB_ALU_OUT; w_u1 = 1'b0;
            end
            OPC_AUIPC: begin
                w_alu = ALU_ADD; w_op1 = 1'b1; w_imm32 = {in_instr[31:12], 12'd0};
                w_we = 1'b1; w_wb = WB_ALU_OUT; w_u1 = 1'b0;
            end
            OPC_JAL: begin
                w_alu = ALU_ADD; w_op1 = 1'b1; w_we = 1'b1; w_wb = WB_RET_ADDR;
                w_br = BR_JAL; w_bret = 1'b1; w_u1 = 1'b0;
                w_imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            end
            OPC_JALR: begin
                w_alu = ALU_ADD; w_we = 1'b1; w_wb = WB_RET_ADDR; w_br = BR_JALR;
                w_bret = 1'b1; w_baddr = 1'b1; w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OPC_BR: begin
                w_br = BR_BR; w_op2 = 1'b1; w_u2 = 1'b1;
                w_imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
                case (w_f3)
                    3'd0:    w_alu = ALU_BEQ;
                    3'd1:    w_alu = ALU_BNE;
                    3'd4:    w_alu = ALU_BLT;
                    3'd5:    w_alu = ALU_BGE;
                    3'd6:    w_alu = ALU_BLTU;
                    3'd7:    w_alu = ALU_BGEU;
                    default: w_ill = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                w_alu = ALU_ADD; w_we = 1'b1; w_wb = WB_LOAD_DATA; w_rre = 1'b1;
                w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                w_rtype = ram_size(w_f3[1:0]); w_rsign = ~w_f3[2];
                w_ill = (w_f3 == 3'd3) || (w_f3 > 3'd5);
            end
            OPC_STORE: begin
                w_alu = ALU_ADD; w_rwe = 1'b1; w_u2 = 1'b1; w_rtype = ram_size(w_f3[1:0]);
                w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                w_ill = (w_f3 > 3'd2);
            end
            OPC_IMM: begin
                w_we = 1'b1; w_wb = WB_ALU_OUT; w_alu = alu_f3(w_f3, in_instr[30]);
                w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                w_ill = (w_f3 == 3'd1 || w_f3 == 3'd5) && (w_f7 != 7'h00) && (w_f7 != 7'h20);
            end
            OPC_OP: begin
                w_we = 1'b1; w_wb = WB_ALU_OUT; w_op2 = 1'b1; w_u2 = 1'b1;
                if (w_f7 == 7'h00)                     w_alu = alu_f3(w_f3, 1'b0);
                else if (w_f7 == 7'h20 && w_f3 == 3'd0) w_alu = ALU_SUB;
                else if (w_f7 == 7'h20 && w_f3 == 3'd5) w_alu = ALU_SRA;
`ifdef DECODE_M_EXT_EN
                else if (w_f7 == 7'h01)                w_alu = {2'b11, w_f3};
`endif
                else                                   w_ill = 1'b1;
            end
            default: w_ill = 1'b1;
        endcase
        // Illegal encodings must not write state nor look like a hazard consumer.
        if (w_ill) begin
            w_alu = 5'd0; w_br = BR_NONE; w_we = 1'b0; w_rwe = 1'b0; w_rre = 1'b0;
            w_rtype = 4'h0; w_imm32 = 32'd0; w_wb = WB_NO_DATA;
            w_op1 = 1'b0; w_op2 = 1'b0; w_bret = 1'b0; w_baddr = 1'b0; w_u1 = 1'b0; w_u2 = 1'b0;
        end
        if (w_rd == '0) w_we = 1'b0;
    end

    assign w_hazard  = r_valid && r_ram_re && (r_rd != '0) && in_valid &&
                       ((w_u1 && w_rs1 == r_rd) || (w_u2 && w_rs2 == r_rd));
    assign in_ready  = !flush && !w_hazard && (!r_valid || out_ready);
    assign w_in_fire = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN; r_valid <= 1'b0; r_stall <= '0; r_pc <= '0; r_imm <= '0;
            r_alu_op <= 5'd0; r_br_type <= BR_NONE; r_wb_sel <= WB_NO_DATA;
            r_rd <= '0; r_rs1 <= '0; r_rs2 <= '0; r_ram_type <= 4'h0;
            r_reg_we <= 1'b0; r_ram_we <= 1'b0; r_ram_re <= 1'b0; r_ram_sign <= 1'b0; r_illegal <= 1'b0;
            r_op1_sel <= 1'b0; r_op2_sel <= 1'b0; r_br_ret_sel <= 1'b0; r_br_addr_sel <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_state <= S_RUN;
        end else if (w_hazard && out_ready && r_state == S_RUN) begin
            r_valid <= 1'b0;
            r_state <= S_BUBBLE;
            if (r_stall != '1) r_stall <= r_stall + CNT_W'(1);
        end else begin
            r_state <= S_RUN;
            if (w_in_fire) begin
                r_valid <= 1'b1; r_pc <= in_pc; r_imm <= XLEN'($signed(w_imm32));
                r_alu_op <= w_alu; r_br_type <= w_br; r_wb_sel <= w_wb;
                r_rd <= w_rd; r_rs1 <= w_rs1; r_rs2 <= w_rs2; r_ram_type <= w_rtype;
                r_reg_we <= w_we; r_ram_we <= w_rwe; r_ram_re <= w_rre; r_ram_sign <= w_rsign;
                r_illegal <= w_ill; r_op1_sel <= w_op1; r_op2_sel <= w_op2;
                r_br_ret_sel <= w_bret; r_br_addr_sel <= w_baddr;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;       assign out_pc = r_pc;             assign out_imm = r_imm;
    assign out_alu_op = r_alu_op;     assign out_br_type = r_br_type;   assign out_wb_sel = r_wb_sel;
    assign out_rd = r_rd;             assign out_rs1 = r_rs1;           assign out_rs2 = r_rs2;
    assign out_reg_we = r_reg_we;     assign out_ram_we = r_ram_we;     assign out_ram_re = r_ram_re;
    assign out_ram_type = r_ram_type; assign out_ram_sign = r_ram_sign; assign out_illegal = r_illegal;
    assign out_op1_sel = r_op1_sel;   assign out_op2_sel = r_op2_sel;
    assign out_br_ret_sel = r_br_ret_sel; assign out_br_addr_sel = r_br_addr_sel;
    assign stall_count = r_stall;
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage with randomized stimulus and reference model
module tb_decode_stage;
    localparam logic [4:0] A_ADD = 5'd1, A_SUB = 5'd2, A_SLL = 5'd3, A_SLT = 5'd4, A_SLTU = 5'd5;
    localparam logic [4:0] A_XOR = 5'd6, A_SRL = 5'd7, A_SRA = 5'd8, A_OR = 5'd9, A_AND = 5'd10, A_LUI = 5'd17;
    localparam logic [1:0] BRN = 2'd0, BJAL = 2'd1, BJALR = 2'd2, BBR = 2'd3;
    localparam logic [1:0] WNONE = 2'd0, WALU = 2'd1, WLOAD = 2'd2, WRET = 2'd3;

    typedef struct packed {
        logic ill; logic [4:0] alu; logic [1:0] br; logic we;
        logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2; logic [31:0] imm;
        logic rwe; logic rre; logic [3:0] rtype; logic rsign;
        logic op1; logic op2; logic bret; logic baddr; logic [1:0] wb;
        logic u1; logic u2; logic [31:0] pc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, in_valid, flush, out_ready;
    logic [31:0] in_instr, in_pc;
    logic in_ready, out_valid, out_reg_we, out_ram_we, out_ram_re, out_ram_sign, out_illegal;
    logic out_op1_sel, out_op2_sel, out_br_ret_sel, out_br_addr_sel;
    logic [31:0] out_pc, out_imm;
    logic [4:0] out_alu_op, out_rd, out_rs1, out_rs2;
    logic [1:0] out_br_type, out_wb_sel;
    logic [3:0] out_ram_type;
    logic [15:0] stall_count;
    logic s_in_ready, s_out_valid, s_reg_we, s_ram_we, s_ram_re, s_ram_sign, s_illegal;
    logic s_op1, s_op2, s_bret, s_baddr;
    logic [31:0] s_pc, s_imm;
    logic [4:0] s_alu, s_rd, s_rs1, s_rs2;
    logic [1:0] s_br, s_wb, s_stall;
    logic [3:0] s_rtype;

    decode_stage u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_alu_op(out_alu_op),
        .out_br_type(out_br_type), .out_reg_we(out_reg_we), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm(out_imm), .out_ram_we(out_ram_we), .out_ram_re(out_ram_re), .out_ram_type(out_ram_type),
        .out_ram_sign(out_ram_sign), .out_op1_sel(out_op1_sel), .out_op2_sel(out_op2_sel),
        .out_br_ret_sel(out_br_ret_sel), .out_br_addr_sel(out_br_addr_sel), .out_wb_sel(out_wb_sel),
        .out_illegal(out_illegal), .stall_count(stall_count));

    decode_stage #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready), .out_pc(s_pc), .out_alu_op(s_alu),
        .out_br_type(s_br), .out_reg_we(s_reg_we), .out_rd(s_rd), .out_rs1(s_rs1), .out_rs2(s_rs2),
        .out_imm(s_imm), .out_ram_we(s_ram_we), .out_ram_re(s_ram_re), .out_ram_type(s_rtype),
        .out_ram_sign(s_ram_sign), .out_op1_sel(s_op1), .out_op2_sel(s_op2),
        .out_br_ret_sel(s_bret), .out_br_addr_sel(s_baddr), .out_wb_sel(s_wb),
        .out_illegal(s_illegal), .stall_count(s_stall));

    exp_t q[$];
    int total = 0, bad = 0, bubbles = 0;
    logic m_full = 1'b0, m_isload = 1'b0;
    logic [4:0] m_rd = 5'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [4:0] alu_of(input logic [2:0] f3);
        case (f3)
            3'd0: return A_ADD;  3'd1: return A_SLL; 3'd2: return A_SLT; 3'd3: return A_SLTU;
            3'd4: return A_XOR;  3'd5: return A_SRL; 3'd6: return A_OR;  default: return A_AND;
        endcase
    endfunction

    function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] sizes [4];
        logic [31:0] imm_i;
        sizes = '{4'h1, 4'h3, 4'hF, 4'h0};
        f3 = ins[14:12]; f7 = ins[31:25];
        imm_i = 32'($signed(ins[31:20]));
        e = '0;
        e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.pc = pc; e.rsign = 1'b1;
        case (ins[6:0])
            7'h37: begin e.alu = A_LUI; e.imm = {ins[31:12], 12'd0}; e.we = 1; e.wb = WALU; end
            7'h17: begin e.alu = A_ADD; e.op1 = 1; e.imm = {ins[31:12], 12'd0}; e.we = 1; e.wb = WALU; end
            7'h6F: begin
                e.alu = A_ADD; e.op1 = 1; e.we = 1; e.wb = WRET; e.br = BJAL; e.bret = 1;
                e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            end
            7'h67: begin
                e.alu = A_ADD; e.imm = imm_i; e.we = 1; e.wb = WRET; e.br = BJALR;
                e.bret = 1; e.baddr = 1; e.u1 = 1;
            end
            7'h63: begin
                e.br = BBR; e.op2 = 1; e.u1 = 1; e.u2 = 1;
                e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
                e.ill = (f3 == 3'd2 || f3 == 3'd3);
                e.alu = (f3 < 3'd2) ? 5'd11 + 5'(f3) : 5'd9 + 5'(f3);
            end
            7'h03: begin
                e.ill = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
                e.alu = A_ADD; e.imm = imm_i; e.we = 1; e.wb = WLOAD; e.rre = 1; e.u1 = 1;
                e.rtype = sizes[f3[1:0]]; e.rsign = !(f3 == 3'd4 || f3 == 3'd5);
            end
            7'h23: begin
                e.ill = f3 > 3'd2; e.alu = A_ADD; e.rwe = 1; e.u1 = 1; e.u2 = 1;
                e.rtype = sizes[f3[1:0]]; e.imm = 32'($signed({ins[31:25], ins[11:7]}));
            end
            7'h13: begin
                e.imm = imm_i; e.we = 1; e.wb = WALU; e.u1 = 1; e.alu = alu_of(f3);
                if (f3 == 3'd5 && ins[30]) e.alu = A_SRA;
                e.ill = (f3 == 3'd1 || f3 == 3'd5) && !(f7 == 7'h00 || f7 == 7'h20);
            end
            7'h33: begin
                e.op2 = 1; e.we = 1; e.wb = WALU; e.u1 = 1; e.u2 = 1;
                if (f7 == 7'h00) e.alu = alu_of(f3);
                else if (f7 == 7'h20 && f3 == 3'd0) e.alu = A_SUB;
                else if (f7 == 7'h20 && f3 == 3'd5) e.alu = A_SRA;
`ifdef DECODE_M_EXT_EN
                else if (f7 == 7'h01) e.alu = 5'd24 + 5'(f3);
`endif
                else e.ill = 1;
            end
            default: e.ill = 1;
        endcase
        if (e.ill) begin
            e.alu = 0; e.br = BRN; e.we = 0; e.rwe = 0; e.rre = 0; e.wb = WNONE; e.u1 = 0; e.u2 = 0;
        end
        if (e.rd == 5'd0) e.we = 0;
        return e;
    endfunction

    // One bus cycle: drive inputs, check the combinational handshake, then advance the model at the edge.
    task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic fl, input logic ordy);
        exp_t d, dropped;
        logic hz, rdy;
        in_valid = v; in_instr = ins; in_pc = pc; flush = fl; out_ready = fl ? 1'b0 : ordy;
        d = ref_dec(ins, pc);
        hz = m_full && m_isload && m_rd != 5'd0 && v && ((d.u1 && d.rs1 == m_rd) || (d.u2 && d.rs2 == m_rd));
        rdy = !fl && !hz && (!m_full || out_ready);
        #2;
        chk("in_ready", in_ready, rdy);
        chk("stall_count", stall_count, bubbles);
        chk("sat_stall", s_stall, bubbles > 3 ? 3 : bubbles);
        chk("sat_mirror", {s_in_ready, s_out_valid, s_pc, s_alu, s_br, s_reg_we, s_rd, s_rs1, s_rs2, s_imm,
                           s_ram_we, s_ram_re, s_rtype, s_ram_sign, s_op1, s_op2, s_bret, s_baddr, s_wb, s_illegal} ==
                          {in_ready, out_valid, out_pc, out_alu_op, out_br_type, out_reg_we, out_rd, out_rs1, out_rs2,
                           out_imm, out_ram_we, out_ram_re, out_ram_type, out_ram_sign, out_op1_sel, out_op2_sel,
                           out_br_ret_sel, out_br_addr_sel, out_wb_sel, out_illegal}, 1);
        @(posedge clk);
        if (fl) begin
            if (m_full) dropped = q.pop_back();
            m_full = 0;
        end else if (hz && out_ready) begin
            m_full = 0; bubbles++;
        end else begin
            if (m_full && out_ready) m_full = 0;
            if (v && rdy) begin q.push_back(d); m_full = 1; m_isload = d.rre; m_rd = d.rd; end
        end
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready && !flush) begin
                if (q.size() == 0) chk("unexpected_output", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("pc", out_pc, e.pc);          chk("illegal", out_illegal, e.ill);
                    chk("alu_op", out_alu_op, e.alu); chk("br_type", out_br_type, e.br);
                    chk("reg_we", out_reg_we, e.we);  chk("wb_sel", out_wb_sel, e.wb);
                    chk("ram_we", out_ram_we, e.rwe); chk("ram_re", out_ram_re, e.rre);
                    chk("rd", out_rd, e.rd); chk("rs1", out_rs1, e.rs1); chk("rs2", out_rs2, e.rs2);
                    if (!e.ill) begin
                        chk("imm", out_imm, e.imm);       chk("ram_type", out_ram_type, e.rtype);
                        chk("ram_sign", out_ram_sign, e.rsign);
                        chk("op1_sel", out_op1_sel, e.op1); chk("op2_sel", out_op2_sel, e.op2);
                        chk("br_ret_sel", out_br_ret_sel, e.bret); chk("br_addr_sel", out_br_addr_sel, e.baddr);
                    end
                end
            end
        end
    end

    initial begin : stim
        logic [6:0] opcs [12];
        logic [6:0] f7;
        logic [31:0] ins;
        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7F, 7'h0F};
        rst = 1; in_valid = 0; flush = 0; out_ready = 0; in_instr = 0; in_pc = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        #2;
        chk("rst_valid", out_valid, 0); chk("rst_stall", stall_count, 0); chk("rst_wb", out_wb_sel, WNONE);
        chk("rst_alu", out_alu_op, 0);  chk("rst_imm", out_imm, 0);       chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        cyc(1, 32'h00500093, 32'h100, 0, 1);
        chk("addi_valid", out_valid, 1); chk("addi_alu", out_alu_op, A_ADD); chk("addi_imm", out_imm, 5);
        chk("addi_rd", out_rd, 1); chk("addi_we", out_reg_we, 1); chk("addi_wb", out_wb_sel, WALU);
        chk("addi_pc", out_pc, 32'h100);
        cyc(0, 0, 0, 0, 1);

        cyc(1, 32'h0000A103, 32'h200, 0, 1);
        cyc(1, 32'h002101B3, 32'h204, 0, 1);
        chk("bubble_valid", out_valid, 0);
        cyc(1, 32'h002101B3, 32'h204, 0, 1);
        chk("lu_stall", stall_count, 1); chk("lu_add_valid", out_valid, 1);
        cyc(1, 32'h0000A003, 32'h300, 0, 1);
        cyc(1, 32'h000001B3, 32'h304, 0, 1);
        chk("x0_no_bubble", out_valid, 1); chk("x0_stall", stall_count, 1);

        cyc(1, 32'h0020A023, 32'h400, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 32'h00500093, 32'h404, 0, 0);
            chk("bp_valid", out_valid, 1); chk("bp_ram_we", out_ram_we, 1);
            chk("bp_ram_type", out_ram_type, 4'hF); chk("bp_pc", out_pc, 32'h400);
        end
        cyc(1, 32'h00500093, 32'h404, 0, 1);
        chk("bp_next_pc", out_pc, 32'h404);

        cyc(1, 32'h00A00113, 32'h500, 1, 0);
        chk("flush_valid", out_valid, 0);
        cyc(1, 32'h0000A103, 32'h600, 0, 1);
        cyc(1, 32'h002101B3, 32'h604, 0, 1);
        cyc(1, 32'h002101B3, 32'h604, 1, 0);
        chk("flush_bub_stall", stall_count, 2); chk("flush_bub_valid", out_valid, 0);
        cyc(1, 32'h002101B3, 32'h604, 0, 1);
        chk("after_flush_pc", out_pc, 32'h604);

        cyc(1, 32'hFFFFFFFF, 32'h700, 0, 1);
        chk("ill_flag", out_illegal, 1); chk("ill_we", out_reg_we, 0); chk("ill_ram_we", out_ram_we, 0);
        chk("ill_ram_re", out_ram_re, 0); chk("ill_br", out_br_type, BRN);
        cyc(1, 32'h027302B3, 32'h704, 0, 1);
`ifdef DECODE_M_EXT_EN
        chk("mul_alu", out_alu_op, 24); chk("mul_ill", out_illegal, 0);
`else
        chk("mul_ill", out_illegal, 1);
`endif

        for (int i = 0; i < 3; i++) begin
            cyc(1, 32'h0000A103, 32'h800, 0, 1);
            cyc(1, 32'h002101B3, 32'h804, 0, 1);
            cyc(1, 32'h002101B3, 32'h804, 0, 1);
        end
        chk("sat_count", s_stall, 3); chk("five_bubbles", stall_count, 5);

        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                2: f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            ins = {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom),
                   5'($urandom_range(0, 3)), opcs[$urandom_range(0, 11)]};
            cyc($urandom_range(0, 3) != 0, ins, {$urandom, 2'b00} & 32'hFFFF_FFFC,
                $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
        end
        repeat (3) cyc(0, 0, 0, 0, 1);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
